tgm: RTL and testbench
======================

# tgm

Test packet generator for the hardware statistics path. Sits upstream of the statistics module in the MD/PHV pipeline: on software command it injects a configured number of test packets (MD+PHV) addressed to the statistics module, in idle slots of the bypass stream. It drives the sent-start/sent-end qualifiers that bracket the counting window. Configuration and readback use the 134-bit control-packet chain.

## Interface
- PLATFORM, "Xilinx", target vendor
- LMID, 8'd6, own module ID on the control chain
- TGT_MID, 8'd7, module ID written into generated MD[87:80]
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low; one clock, all logic on posedge clk
- in_tgm_md / in_tgm_md_wr  in  256/1  upstream metadata
- in_tgm_phv / in_tgm_phv_wr  in  1024/1  upstream PHV
- out_tgm_md_alf, out_tgm_phv_alf  out  1  = in_tgm_md_alf, in_tgm_phv_alf (combinational)
- out_tgm_md / out_tgm_md_wr  out  256/1  downstream metadata
- out_tgm_phv / out_tgm_phv_wr  out  1024/1  downstream PHV
- in_tgm_md_alf, in_tgm_phv_alf  in  1  downstream almost-full
- tgm2scm_sent_start, tgm2scm_sent_end  out  1  counting-window qualifiers (levels)
- cin_tgm_data / cin_tgm_data_wr  in  134/1  control packets in
- cout_tgm_ready  out  1  = cin_tgm_ready
- cout_tgm_data / cout_tgm_data_wr  out  134/1  control packets out
- cin_tgm_ready  in  1  downstream control ready

## Operation
- Reset (rst_n=0 at posedge): all outputs 0; state IDLE_S; protocol_type=0, pkt_num=0, pkt_len=12'd64, gap=0, sent_cnt=0, seq=0, timestamp=0.
- timestamp: free-running 32-bit, +1 every cycle, wraps 0xFFFFFFFF->0.
- Control chain: header beat [133:132]=01, tail [133:132]=10. Op [126:124]: 010 write, 001 read. Dest MID [103:96], address [95:64], data [31:0] of header.
  - Write to LMID: header and following tail consumed (cout_tgm_data_wr=0). Addresses: 0x60000000 protocol_type[7:0]; 0x60000001 pkt_num[31:0]; 0x60000002 pkt_len[11:0]; 0x60000003 gap[15:0]; 0x60000004 start (bit0); 0x60000005 abort (bit0). Writes to 0x60000000-3 ignored outside IDLE_S/DONE_S.
  - Read to LMID, address 0x60000008 (sent_cnt) or 0x60000009 (timestamp): header forwarded as {hdr[133:128], 4'b1011, hdr[123:112], hdr[103:96], hdr[111:104], hdr[95:32], value}; other addresses forwarded unchanged; tail forwarded unchanged.
  - All other beats forwarded unchanged. Non-write beats appear on cout one cycle after cin.
- Generated MD: [108]=0, [107:96]=pkt_len, [87:80]=TGT_MID, [79:72]=protocol_type, [63:32]=seq, [31:0]=timestamp at emit; all other bits 0. Generated PHV: [31:0]=seq, rest 0.
- Bypass: upstream beat registered to output, 1-cycle latency, always wins the output slot.
- FSM:
  - IDLE_S: start=1 and pkt_num!=0 -> ARM_S; start with pkt_num=0 -> DONE_S (sent_end=1, sent_start stays 0).
  - ARM_S: clear sent_cnt, seq; sent_start<=1, sent_end<=0; -> GEN_S.
  - GEN_S: emit when in_tgm_md_wr=0, in_tgm_phv_wr=0, in_tgm_md_alf=0, in_tgm_phv_alf=0; on emit sent_cnt++, seq++; if new sent_cnt==pkt_num -> DONE_S; else gap=0 -> GEN_S, gap>0 -> GAP_S loading gap counter with gap.
  - GAP_S: count down each cycle; at 1 -> GEN_S (exactly gap idle cycles between generated packets, ignoring stalls).
  - DONE_S: sent_end<=1, sent_start held 1 if it was set. start=1 -> ARM_S (pkt_num!=0) as from IDLE_S.
  - Abort=1 in any state: -> IDLE_S, sent_start=0, sent_end=0, sent_cnt retained. Start while in ARM/GEN/GAP ignored.
- Simultaneous abort and start in one header impossible (distinct addresses); start and reset same cycle: reset wins.

## Timing
- Start header on cin at cycle T -> state ARM_S at T+1, sent_start=1 at T+2, first generated beat on out earliest T+3 (registered).
- sent_end=1 the cycle after the last generated beat is visible on out.
- Generated beat stalled indefinitely while upstream writes or alf asserted; no beat lost or duplicated.
- md_wr and phv_wr always asserted together for generated packets.

## Test plan
- Reset: hold rst_n=0 two cycles with traffic on all inputs -> every output 0, read of 0x60000008 returns 0.
- Basic run: pkt_num=4, pkt_len=100, protocol_type=1, gap=2, start -> 4 beats with MD[87:80]=7, [79:72]=1, [107:96]=100, seq 0..3, exactly 2 idle cycles between, sent_end=1 after 4th.
- Contention: upstream writes every cycle for 10 cycles during GEN_S -> 10 bypass beats unchanged at 1-cycle latency, first generated beat in cycle after last bypass beat.
- Backpressure: in_tgm_md_alf=1 for 20 cycles mid-run, pkt_num=8 -> no generated beat during alf, total exactly 8, sent_cnt read returns 8.
- Control chain: read 0x60000008 to MID 6 -> response with [127:124]=1011, MIDs swapped, [31:0]=sent_cnt; write to MID 9 -> forwarded unchanged; write to MID 6 -> header and tail dropped.
- Abort/zero: abort during GAP_S -> IDLE_S, both qualifiers 0 next cycle; start with pkt_num=0 -> no beats, sent_end=1, sent_start=0.

Source files
------------

// File: rtl/tgm.sv
// Test packet generator: registers the bypass stream (1 cycle, bypass always wins) and injects
// MD/PHV test packets only in slots with no upstream write and no downstream almost-full.
module tgm #(
  parameter string      PLATFORM = "Xilinx",
  parameter logic [7:0] LMID     = 8'd6,
  parameter logic [7:0] TGT_MID  = 8'd7
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [255:0]   in_tgm_md,
  input  logic           in_tgm_md_wr,
  input  logic [1023:0]  in_tgm_phv,
  input  logic           in_tgm_phv_wr,
  output logic           out_tgm_md_alf,
  output logic           out_tgm_phv_alf,
  output logic [255:0]   out_tgm_md,
  output logic           out_tgm_md_wr,
  output logic [1023:0]  out_tgm_phv,
  output logic           out_tgm_phv_wr,
  input  logic           in_tgm_md_alf,
  input  logic           in_tgm_phv_alf,
  output logic           tgm2scm_sent_start,
  output logic           tgm2scm_sent_end,
  input  logic [133:0]   cin_tgm_data,
  input  logic           cin_tgm_data_wr,
  output logic           cout_tgm_ready,
  output logic [133:0]   cout_tgm_data,
  output logic           cout_tgm_data_wr,
  input  logic           cin_tgm_ready
);

  if (PLATFORM != "Xilinx") begin : g_platform_chk
    $error("tgm: unsupported PLATFORM");
  end

  typedef enum logic [2:0] {IDLE_S, ARM_S, GEN_S, GAP_S, DONE_S} state_e;

  state_e         state_q, state_d;
  logic [31:0]    timestamp_q;
  logic [7:0]     protocol_type_q;
  logic [31:0]    pkt_num_q, sent_cnt_q, seq_q;
  logic [11:0]    pkt_len_q;
  logic [15:0]    gap_q, gap_cnt_q;
  logic           sent_start_q, sent_end_q;
  logic           drop_q;
  logic [255:0]   out_md_q;
  logic [1023:0]  out_phv_q;
  logic           out_md_wr_q, out_phv_wr_q;
  logic [133:0]   cout_data_q;
  logic           cout_wr_q;

  logic           is_hdr, is_tail, for_me, cfg_wr, cfg_rd, start_cmd, abort_cmd, cfg_open;
  logic           drop_beat, rd_hit, emit, slot_free;
  logic [31:0]    addr, wdata, rd_val;
  logic [255:0]   gen_md;
  logic [1023:0]  gen_phv;

  assign is_hdr    = cin_tgm_data_wr && (cin_tgm_data[133:132] == 2'b01);
  assign is_tail   = cin_tgm_data_wr && (cin_tgm_data[133:132] == 2'b10);
  assign for_me    = (cin_tgm_data[103:96] == LMID);
  assign addr      = cin_tgm_data[95:64];
  assign wdata     = cin_tgm_data[31:0];
  assign cfg_wr    = is_hdr && for_me && (cin_tgm_data[126:124] == 3'b010);
  assign cfg_rd    = is_hdr && for_me && (cin_tgm_data[126:124] == 3'b001);
  assign start_cmd = cfg_wr && (addr == 32'h6000_0004) && wdata[0];
  assign abort_cmd = cfg_wr && (addr == 32'h6000_0005) && wdata[0];
  assign cfg_open  = (state_q == IDLE_S) || (state_q == DONE_S);
  // A consumed write swallows its header and everything up to and including the tail.
  assign drop_beat = cfg_wr || (drop_q && cin_tgm_data_wr);
  assign rd_hit    = cfg_rd && ((addr == 32'h6000_0008) || (addr == 32'h6000_0009));
  assign rd_val    = (addr == 32'h6000_0009) ? timestamp_q : sent_cnt_q;
  assign slot_free = !in_tgm_md_wr && !in_tgm_phv_wr && !in_tgm_md_alf && !in_tgm_phv_alf;

  always_comb begin
    gen_md          = '0;
    gen_md[107:96]  = pkt_len_q;
    gen_md[87:80]   = TGT_MID;
    gen_md[79:72]   = protocol_type_q;
    gen_md[63:32]   = seq_q;
    gen_md[31:0]    = timestamp_q;
    gen_phv         = '0;
    gen_phv[31:0]   = seq_q;
  end

  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    case (state_q)
      IDLE_S, DONE_S: if (start_cmd) state_d = (pkt_num_q != 32'd0) ? ARM_S : DONE_S;
      ARM_S:          state_d = GEN_S;
      GEN_S: begin
        if (slot_free) begin
          emit = 1'b1;
          if (sent_cnt_q + 32'd1 == pkt_num_q) state_d = DONE_S;
          else if (gap_q != 16'd0)             state_d = GAP_S;
        end
      end
      GAP_S:          if (gap_cnt_q <= 16'd1) state_d = GEN_S;
      default:        state_d = IDLE_S;
    endcase
    if (abort_cmd) begin
      state_d = IDLE_S;
      emit    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE_S;
      timestamp_q     <= '0;
      protocol_type_q <= '0;
      pkt_num_q       <= '0;
      pkt_len_q       <= 12'd64;
      gap_q           <= '0;
      gap_cnt_q       <= '0;
      sent_cnt_q      <= '0;
      seq_q           <= '0;
      sent_start_q    <= 1'b0;
      sent_end_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timestamp_q <= timestamp_q + 32'd1;
      if (cfg_wr && cfg_open) begin
        case (addr)
          32'h6000_0000: protocol_type_q <= wdata[7:0];
          32'h6000_0001: pkt_num_q       <= wdata;
          32'h6000_0002: pkt_len_q       <= wdata[11:0];
          32'h6000_0003: gap_q           <= wdata[15:0];
          default: ;
        endcase
      end
      if (abort_cmd) begin
        sent_start_q <= 1'b0;
        sent_end_q   <= 1'b0;
      end else if (state_q == ARM_S) begin
        sent_start_q <= 1'b1;
        sent_end_q   <= 1'b0;
        sent_cnt_q   <= '0;
        seq_q        <= '0;
      end else if (state_q == DONE_S) begin
        sent_end_q <= 1'b1;
      end
      if (emit) begin
        sent_cnt_q <= sent_cnt_q + 32'd1;
        seq_q      <= seq_q + 32'd1;
      end
      if (state_q == GEN_S && state_d == GAP_S) gap_cnt_q <= gap_q;
      else if (state_q == GAP_S)                gap_cnt_q <= gap_cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_md_q     <= '0;
      out_phv_q    <= '0;
      out_md_wr_q  <= 1'b0;
      out_phv_wr_q <= 1'b0;
      cout_data_q  <= '0;
      cout_wr_q    <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      out_md_wr_q  <= in_tgm_md_wr || emit;
      out_phv_wr_q <= in_tgm_phv_wr || emit;
      if (in_tgm_md_wr)  out_md_q  <= in_tgm_md;
      else if (emit)     out_md_q  <= gen_md;
      if (in_tgm_phv_wr) out_phv_q <= in_tgm_phv;
      else if (emit)     out_phv_q <= gen_phv;

      if (cfg_wr)                drop_q <= 1'b1;
      else if (drop_q && is_tail) drop_q <= 1'b0;
      cout_wr_q <= cin_tgm_data_wr && !drop_beat;
      // Read response: opcode nibble rewritten, source/destination MIDs swapped.
      if (rd_hit) cout_data_q <= {cin_tgm_data[133:128], 4'b1011, cin_tgm_data[123:112],
                                  cin_tgm_data[103:96], cin_tgm_data[111:104],
                                  cin_tgm_data[95:32], rd_val};
      else        cout_data_q <= cin_tgm_data;
    end
  end

  assign out_tgm_md_alf     = in_tgm_md_alf;
  assign out_tgm_phv_alf    = in_tgm_phv_alf;
  assign cout_tgm_ready     = cin_tgm_ready;
  assign out_tgm_md         = out_md_q;
  assign out_tgm_md_wr      = out_md_wr_q;
  assign out_tgm_phv        = out_phv_q;
  assign out_tgm_phv_wr     = out_phv_wr_q;
  assign tgm2scm_sent_start = sent_start_q;
  assign tgm2scm_sent_end   = sent_end_q;
  assign cout_tgm_data      = cout_data_q;
  assign cout_tgm_data_wr   = cout_wr_q;

endmodule

// File: tb/tb_tgm.sv
// Scoreboard bench for tgm: stimulus pushes expected beats into queues, a negedge monitor
// pops and compares bypass, generated and control-chain outputs.
`timescale 1ns/1ps
module tb_tgm;
  localparam logic [7:0] LMID = 8'd6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [255:0]   in_md, out_md;
  logic [1023:0]  in_phv, out_phv;
  logic           in_md_wr, in_phv_wr, out_md_wr, out_phv_wr;
  logic           in_md_alf, in_phv_alf, out_md_alf, out_phv_alf;
  logic           sent_start, sent_end;
  logic [133:0]   cin_data, cout_data;
  logic           cin_wr, cout_wr, cin_ready, cout_ready;

  tgm dut (
    .clk(clk), .rst_n(rst_n),
    .in_tgm_md(in_md), .in_tgm_md_wr(in_md_wr),
    .in_tgm_phv(in_phv), .in_tgm_phv_wr(in_phv_wr),
    .out_tgm_md_alf(out_md_alf), .out_tgm_phv_alf(out_phv_alf),
    .out_tgm_md(out_md), .out_tgm_md_wr(out_md_wr),
    .out_tgm_phv(out_phv), .out_tgm_phv_wr(out_phv_wr),
    .in_tgm_md_alf(in_md_alf), .in_tgm_phv_alf(in_phv_alf),
    .tgm2scm_sent_start(sent_start), .tgm2scm_sent_end(sent_end),
    .cin_tgm_data(cin_data), .cin_tgm_data_wr(cin_wr),
    .cout_tgm_ready(cout_ready),
    .cout_tgm_data(cout_data), .cout_tgm_data_wr(cout_wr),
    .cin_tgm_ready(cin_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) if (!rst_n) cyc = 0; else cyc = cyc + 1;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm, input int a, input int e);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", nm, a, e, cyc);
  endtask

  task automatic check_phv(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    for (int i = 0; i < 4; i++) check(nm, act[i*256 +: 256], exp[i*256 +: 256]);
  endtask

  typedef struct { logic [255:0] md; logic [1023:0] phv; int due; } byp_t;
  typedef struct { logic [255:0] md; logic [1023:0] phv; } gen_t;
  typedef struct { logic [133:0] d; int due; } ctl_t;
  byp_t byp_q[$];
  gen_t gen_q[$];
  ctl_t ctl_q[$];
  int   gen_cyc[$];
  int   gen_seen = 0;
  bit   mon_en = 0;
  logic prev_blocked = 1'b0;
  byp_t mb;
  gen_t mg;
  ctl_t mc;
  logic [255:0] exp_md;

  always @(negedge clk) if (mon_en) begin
    while (byp_q.size() > 0 && byp_q[0].due < cyc) begin
      fail_now("bypass_beat_missing", cyc, byp_q[0].due);
      void'(byp_q.pop_front());
    end
    if (out_md_wr || out_phv_wr) begin
      check("md_phv_wr_together", 256'(out_md_wr), 256'(out_phv_wr));
      if (byp_q.size() > 0 && byp_q[0].due == cyc) begin
        mb = byp_q.pop_front();
        check("bypass_md", out_md, mb.md);
        check_phv("bypass_phv", out_phv, mb.phv);
      end else if (gen_q.size() > 0) begin
        mg = gen_q.pop_front();
        exp_md = mg.md;
        exp_md[31:0] = 32'(cyc - 1);
        check("gen_md", out_md, exp_md);
        check_phv("gen_phv", out_phv, mg.phv);
        check("gen_in_blocked_slot", 256'(prev_blocked), 256'(0));
        gen_seen++;
        gen_cyc.push_back(cyc);
      end else fail_now("unexpected_data_beat", 1, 0);
    end
    while (ctl_q.size() > 0 && ctl_q[0].due < cyc) begin
      fail_now("ctl_beat_missing", cyc, ctl_q[0].due);
      void'(ctl_q.pop_front());
    end
    if (cout_wr) begin
      if (ctl_q.size() > 0 && ctl_q[0].due == cyc) begin
        mc = ctl_q.pop_front();
        check("ctl_data", 256'(cout_data), 256'(mc.d));
      end else fail_now("unexpected_ctl_beat", 1, 0);
    end
    prev_blocked = in_md_wr | in_phv_wr | in_md_alf | in_phv_alf;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [133:0] mk_hdr(input logic [2:0] op, input logic [7:0] mid,
                                          input logic [31:0] addr, input logic [31:0] data);
    logic [133:0] h;
    h = '0;
    h[31:0]    = data;
    h[63:32]   = $urandom;
    h[95:64]   = addr;
    h[103:96]  = mid;
    h[111:104] = 8'($urandom);
    h[123:112] = 12'($urandom);
    h[126:124] = op;
    h[127]     = 1'($urandom);
    h[131:128] = 4'($urandom);
    h[133:132] = 2'b01;
    return h;
  endfunction

  function automatic logic [133:0] mk_tail();
    logic [133:0] t;
    for (int i = 0; i < 4; i++) t[i*32 +: 32] = $urandom;
    t[131:128] = 4'($urandom);
    t[133:132] = 2'b10;
    return t;
  endfunction

  task automatic cbeat(input logic [133:0] d, input bit fwd, input logic [133:0] exp);
    cin_data = d;
    cin_wr   = 1'b1;
    if (fwd) ctl_q.push_back('{d: exp, due: cyc + 1});
    tick();
    cin_wr   = 1'b0;
    cin_data = '0;
  endtask

  task automatic cwrite(input logic [7:0] mid, input logic [31:0] addr, input logic [31:0] data,
                        output int t_hdr);
    logic [133:0] h, t;
    h = mk_hdr(3'b010, mid, addr, data);
    t = mk_tail();
    t_hdr = cyc;
    cbeat(h, mid != LMID, h);
    cbeat(t, mid != LMID, t);
  endtask

  task automatic cread(input logic [7:0] mid, input logic [31:0] addr, input logic [31:0] cnt_exp);
    logic [133:0] h, r;
    logic [31:0] v;
    h = mk_hdr(3'b001, mid, addr, 32'($urandom));
    r = h;
    if (mid == LMID && (addr == 32'h6000_0008 || addr == 32'h6000_0009)) begin
      v = (addr == 32'h6000_0008) ? cnt_exp : 32'(cyc);
      r = {h[133:128], 4'b1011, h[123:112], h[103:96], h[111:104], h[95:32], v};
    end
    cbeat(h, 1'b1, r);
    cbeat(mk_tail(), 1'b1, '0);
    ctl_q[ctl_q.size() - 1].d = cin_data_last;
  endtask

  logic [133:0] cin_data_last;
  always @(posedge clk) if (cin_wr) cin_data_last <= cin_data;

  task automatic cfg(input int pn, input int len, input int proto, input int gap);
    int t;
    cwrite(LMID, 32'h6000_0000, 32'(proto), t);
    cwrite(LMID, 32'h6000_0001, 32'(pn), t);
    cwrite(LMID, 32'h6000_0002, 32'(len), t);
    cwrite(LMID, 32'h6000_0003, 32'(gap), t);
  endtask

  task automatic push_gen(input int n, input int len, input int proto);
    gen_t g;
    for (int i = 0; i < n; i++) begin
      g.md = '0;
      g.md[107:96] = 12'(len);
      g.md[87:80]  = 8'd7;
      g.md[79:72]  = 8'(proto);
      g.md[63:32]  = 32'(i);
      g.phv = '0;
      g.phv[31:0] = 32'(i);
      gen_q.push_back(g);
    end
  endtask

  task automatic new_run();
    gen_seen = 0;
    gen_cyc.delete();
  endtask

  task automatic wait_gen(input int n, input int budget);
    int k = 0;
    while (gen_seen < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (gen_seen < n) fail_now("wait_gen_timeout", gen_seen, n);
  endtask

  task automatic drive_bypass();
    in_md     = {8{$urandom}};
    in_phv    = {32{$urandom}};
    in_md_wr  = 1'b1;
    in_phv_wr = 1'b1;
    byp_q.push_back('{md: in_md, phv: in_phv, due: cyc + 1});
  endtask

  initial begin
    int t, len, proto, last_due, snap;
    rst_n = 1'b0; cin_ready = 1'b1;
    in_md_alf = 1'b0; in_phv_alf = 1'b0;
    in_md = {8{$urandom}}; in_phv = {32{$urandom}}; in_md_wr = 1'b1; in_phv_wr = 1'b1;
    cin_data = mk_hdr(3'b001, LMID, 32'h6000_0008, 0); cin_wr = 1'b1;
    tick(); tick();
    check("rst_out_md_wr", 256'(out_md_wr), 0);
    check("rst_out_phv_wr", 256'(out_phv_wr), 0);
    check("rst_out_md", out_md, 0);
    check_phv("rst_out_phv", out_phv, '0);
    check("rst_sent_start", 256'(sent_start), 0);
    check("rst_sent_end", 256'(sent_end), 0);
    check("rst_cout_wr", 256'(cout_wr), 0);
    check("rst_cout_data", 256'(cout_data), 0);
    check("cout_ready_pass", 256'(cout_ready), 1);
    in_md_wr = 1'b0; in_phv_wr = 1'b0; cin_wr = 1'b0; rst_n = 1'b1; mon_en = 1'b1;
    tick();
    cread(LMID, 32'h6000_0008, 0);
    cread(LMID, 32'h6000_0009, 0);

    // Basic run: 4 packets, gap 2
    new_run();
    cfg(4, 100, 1, 2);
    push_gen(4, 100, 1);
    t = cyc;
    cbeat(mk_hdr(3'b010, LMID, 32'h6000_0004, 1), 1'b0, '0);
    check("start_T1_sent_start", 256'(sent_start), 0);
    cbeat(mk_tail(), 1'b0, '0);
    check("start_T2_sent_start", 256'(sent_start), 1);
    wait_gen(4, 100);
    if (gen_cyc.size() == 4) begin
      check("first_beat_cycle", 256'(gen_cyc[0]), 256'(t + 3));
      for (int i = 1; i < 4; i++) check("gap_spacing", 256'(gen_cyc[i] - gen_cyc[i-1]), 256'(3));
    end
    check("sent_end_with_last", 256'(sent_end), 0);
    @(negedge clk); #1;
    check("sent_end_after_last", 256'(sent_end), 1);
    check("sent_start_held", 256'(sent_start), 1);
    cread(LMID, 32'h6000_0008, 4);

    // Contention: 10 bypass beats right as generation begins
    new_run();
    len = $urandom_range(1, 4095); proto = $urandom_range(0, 255);
    cfg(6, len, proto, 0);
    push_gen(6, len, proto);
    cwrite(LMID, 32'h6000_0004, 1, t);
    for (int i = 0; i < 10; i++) begin
      drive_bypass();
      last_due = cyc + 1;
      tick();
    end
    in_md_wr = 1'b0; in_phv_wr = 1'b0;
    wait_gen(6, 100);
    if (gen_cyc.size() == 6) begin
      check("gen_after_bypass", 256'(gen_cyc[0]), 256'(last_due + 1));
      check("gen_back_to_back", 256'(gen_cyc[5] - gen_cyc[0]), 256'(5));
    end

    // Backpressure plus random upstream traffic
    new_run();
    len = $urandom_range(1, 4095); proto = $urandom_range(0, 255);
    cfg(8, len, proto, 1);
    push_gen(8, len, proto);
    cwrite(LMID, 32'h6000_0004, 1, t);
    wait_gen(2, 100);
    in_md_alf = 1'b1;
    check("md_alf_pass", 256'(out_md_alf), 1);
    snap = gen_seen;
    cwrite(LMID, 32'h6000_0002, 5, t);
    repeat (18) tick();
    check("no_gen_during_alf", 256'(gen_seen), 256'(snap));
    in_md_alf = 1'b0;
    for (int i = 0; i < 30; i++) begin
      in_phv_alf = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) drive_bypass();
      else begin in_md_wr = 1'b0; in_phv_wr = 1'b0; end
      tick();
    end
    in_md_wr = 1'b0; in_phv_wr = 1'b0; in_phv_alf = 1'b0;
    wait_gen(8, 300);
    repeat (5) tick();
    check("bp_total_beats", 256'(gen_seen), 256'(8));
    cread(LMID, 32'h6000_0008, 8);

    // Control chain mix
    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(0, 4))
        0: cwrite(8'd9, $urandom, $urandom, t);
        1: cread(LMID, 32'h6000_0003, 0);
        2: cread(LMID, 32'h6000_0009, 0);
        3: cwrite(LMID, 32'h6000_000A + 32'($urandom_range(0, 5)), $urandom, t);
        default: begin
          cin_data = mk_tail();
          cin_data[133:132] = 2'b11;
          cbeat(cin_data, 1'b1, cin_data);
        end
      endcase
    end
    cread(8'd9, 32'h6000_0008, 0);
    cread(LMID, 32'h6000_0008, 8);
    repeat (3) tick();

    // Abort during GAP_S
    new_run();
    len = $urandom_range(1, 4095); proto = $urandom_range(0, 255);
    cfg(5, len, proto, 6);
    push_gen(5, len, proto);
    cwrite(LMID, 32'h6000_0004, 1, t);
    wait_gen(2, 100);
    cbeat(mk_hdr(3'b010, LMID, 32'h6000_0005, 1), 1'b0, '0);
    check("abort_sent_start", 256'(sent_start), 0);
    check("abort_sent_end", 256'(sent_end), 0);
    cbeat(mk_tail(), 1'b0, '0);
    repeat (15) tick();
    gen_q.delete();
    check("abort_beats", 256'(gen_seen), 256'(2));
    cread(LMID, 32'h6000_0008, 2);

    // Start with pkt_num = 0
    cwrite(LMID, 32'h6000_0001, 0, t);
    cwrite(LMID, 32'h6000_0004, 1, t);
    check("zero_sent_end", 256'(sent_end), 1);
    check("zero_sent_start", 256'(sent_start), 0);
    repeat (10) tick();
    check("zero_no_beats", 256'(gen_seen), 256'(2));

    repeat (3) tick();
    check("byp_q_drained", 256'(byp_q.size()), 0);
    check("gen_q_drained", 256'(gen_q.size()), 0);
    check("ctl_q_drained", 256'(ctl_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
